gpio_irq_ctrl: RTL and testbench

Interrupt sequencer for the 8-bit GPIO block. It watches the GPIO per-pin interrupt outputs and picks one pending source at a time, round-robin. It presents that source to the CPU as a single interrupt with an ID. After the CPU acknowledges, it clears the source by issuing an APB write to the GPIO `porta_eoi` register through its own APB master port. The block sits between the GPIO `gpio_intr` outputs, the CPU interrupt input, and an APB master slot on the peripheral bus.

---
 rtl/gpio_irq_ctrl_pkg.sv | 33 +++
 rtl/gpio_irq_ctrl_if.sv | 25 ++
 rtl/gpio_rr_pick.sv | 34 +++
 rtl/gpio_irq_ctrl.sv | 147 ++++++++++++++
 tb/tb_gpio_irq_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared definitions for the GPIO interrupt sequencer: FSM encoding, EOI
// target address and the GPIO register word map used across the subsystem.
package gpio_irq_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NOTIFY = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_GUARD  = 3'd4
    } state_e;

    localparam logic [4:0] EOI_WADDR_DFLT = 5'h13;

    // GPIO register word addresses (paddr[6:2])
    localparam logic [4:0] GPIO_PORTA_DR_WA       = 5'h00;
    localparam logic [4:0] GPIO_PORTA_DDR_WA      = 5'h01;
    localparam logic [4:0] GPIO_INTEN_WA          = 5'h0C;
    localparam logic [4:0] GPIO_INTMASK_WA        = 5'h0D;
    localparam logic [4:0] GPIO_INTTYPE_LEVEL_WA  = 5'h0E;
    localparam logic [4:0] GPIO_INT_POLARITY_WA   = 5'h0F;
    localparam logic [4:0] GPIO_INTSTATUS_WA      = 5'h10;
    localparam logic [4:0] GPIO_RAW_INTSTATUS_WA  = 5'h11;
    localparam logic [4:0] GPIO_DEBOUNCE_WA       = 5'h12;
    localparam logic [4:0] GPIO_PORTA_EOI_WA      = 5'h13;
    localparam logic [4:0] GPIO_EXT_PORTA_WA      = 5'h14;

    // Write-one-to-clear pattern for a single source
    function automatic logic [31:0] eoi_bit(input logic [2:0] id);
        return 32'h1 << id;
    endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// CPU interrupt handshake plus APB master bus of the interrupt sequencer.
// master = sequencer side, slave = CPU / APB completer side.
interface gpio_irq_ctrl_if;

    logic        cpu_irq;
    logic [2:0]  irq_id;
    logic        irq_ack;
    logic [4:0]  m_paddr;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [31:0] m_pwdata;
    logic        m_pready;

    modport master (
        output cpu_irq, irq_id, m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        input  irq_ack, m_pready
    );

    modport slave (
        input  cpu_irq, irq_id, m_paddr, m_psel, m_penable, m_pwrite, m_pwdata,
        output irq_ack, m_pready
    );

endinterface

// File: rtl/gpio_rr_pick.sv
// Round-robin picker: first pending source after last_id, wrapping mod NUM_SRC.
// Purely combinational; no backpressure.
module gpio_rr_pick #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] pending,
    input  logic [2:0]         last_id,
    output logic               vld,
    output logic [2:0]         winner
);

    logic [15:0] pend_ext;
    logic [3:0]  idx;

    assign pend_ext = 16'(pending);

    always_comb begin
        vld    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // last_id+1+i never exceeds 2*NUM_SRC-1, so one wrap suffices
            idx = 4'(last_id) + 4'(i) + 4'd1;
            if (idx >= 4'(NUM_SRC)) begin
                idx = idx - 4'(NUM_SRC);
            end
            if (!vld && pend_ext[idx]) begin
                vld    = 1'b1;
                winner = idx[2:0];
            end
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// Serves one GPIO interrupt at a time to the CPU, then clears it with an APB EOI write.
// Latency: pending->cpu_irq 1 cycle; ack->psel 1 cycle; all outputs registered.
// Backpressure: CPU via irq_ack, APB completer via m_pready (ACCESS holds stable).
module gpio_irq_ctrl
    import gpio_irq_defs::*;
#(
    parameter int         NUM_SRC   = 8,
    parameter logic [4:0] EOI_WADDR = EOI_WADDR_DFLT,
    parameter int         GUARD_CYC = 2
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [NUM_SRC-1:0] gpio_intr,
    input  logic [NUM_SRC-1:0] src_mask,
    output logic               busy,
    gpio_irq_ctrl_if.master    bus
);

    localparam logic [2:0] LAST_RST = 3'(NUM_SRC - 1);

    state_e      state_q, state_d;
    logic [2:0]  cur_id_q, cur_id_d;
    logic [2:0]  last_id_q, last_id_d;
    logic [3:0]  guard_q, guard_d;

    logic        cpu_irq_q, cpu_irq_d;
    logic [2:0]  irq_id_q, irq_id_d;
    logic [4:0]  paddr_q, paddr_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        busy_q, busy_d;

    logic [NUM_SRC-1:0] pending;
    logic               pick_vld;
    logic [2:0]         pick_id;
    logic               apb_act;

    assign pending = gpio_intr & ~src_mask;

    gpio_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .pending (pending),
        .last_id (last_id_q),
        .vld     (pick_vld),
        .winner  (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        guard_d   = guard_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    cur_id_d  = pick_id;
                    last_id_d = pick_id;
                    state_d   = ST_NOTIFY;
                end
            end
            ST_NOTIFY: begin
                if (bus.irq_ack) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.m_pready) begin
                    state_d = ST_GUARD;
                    guard_d = 4'(GUARD_CYC);
                end
            end
            ST_GUARD: begin
                if (guard_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered images of the next state
        apb_act   = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        cpu_irq_d = (state_d == ST_NOTIFY);
        irq_id_d  = cpu_irq_d ? cur_id_d : 3'd0;
        psel_d    = apb_act;
        penable_d = (state_d == ST_ACCESS);
        pwrite_d  = apb_act;
        paddr_d   = apb_act ? EOI_WADDR : 5'd0;
        pwdata_d  = apb_act ? eoi_bit(cur_id_d) : 32'd0;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            cur_id_q  <= 3'd0;
            last_id_q <= LAST_RST;
            guard_q   <= 4'd0;
        end else begin
            state_q   <= state_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            guard_q   <= guard_d;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cpu_irq_q <= 1'b0;
            irq_id_q  <= 3'd0;
            paddr_q   <= 5'd0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 32'd0;
            busy_q    <= 1'b0;
        end else begin
            cpu_irq_q <= cpu_irq_d;
            irq_id_q  <= irq_id_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.cpu_irq   = cpu_irq_q;
    assign bus.irq_id    = irq_id_q;
    assign bus.m_paddr   = paddr_q;
    assign bus.m_psel    = psel_q;
    assign bus.m_penable = penable_q;
    assign bus.m_pwrite  = pwrite_q;
    assign bus.m_pwdata  = pwdata_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Directed bench for gpio_irq_ctrl: stimulus pushes expected IRQ IDs and EOI writes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_gpio_irq_ctrl;

    localparam logic [4:0] EOI_ADDR = 5'h13;

    logic       pclk;
    logic       presetn;
    logic [7:0] gpio_intr;
    logic [7:0] src_mask;
    logic       busy;

    gpio_irq_ctrl_if bus();

    gpio_irq_ctrl #(
        .NUM_SRC   (8),
        .EOI_WADDR (5'h13),
        .GUARD_CYC (2)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .gpio_intr (gpio_intr),
        .src_mask  (src_mask),
        .busy      (busy),
        .bus       (bus.master)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        bit          is_eoi;
        logic [31:0] val;
    } exp_t;

    exp_t expq[$];
    int   nvec  = 0;
    int   nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_irq(input int id);
        exp_t e;
        e.is_eoi = 1'b0;
        e.val    = 32'(id);
        expq.push_back(e);
    endtask

    task automatic push_eoi(input logic [31:0] data);
        exp_t e;
        e.is_eoi = 1'b1;
        e.val    = data;
        expq.push_back(e);
    endtask

    // Monitor: IRQ rising edges and every APB beat are compared against the queue head
    initial begin
        logic irq_prev;
        exp_t e;
        irq_prev = 1'b0;
        forever begin
            @(negedge pclk);
            if (bus.cpu_irq && !irq_prev) begin
                if (expq.size() == 0 || expq[0].is_eoi) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_irq: got id %0d, expected no interrupt (t=%0t)", bus.irq_id, $time);
                end else begin
                    e = expq.pop_front();
                    check("irq_id", 32'(bus.irq_id), e.val);
                end
            end
            irq_prev = bus.cpu_irq;
            if (bus.m_psel) begin
                if (expq.size() == 0 || !expq[0].is_eoi) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_apb: got data %0h, expected no transfer (t=%0t)", bus.m_pwdata, $time);
                end else begin
                    check("eoi_addr", 32'(bus.m_paddr), 32'(EOI_ADDR));
                    check("eoi_data", bus.m_pwdata, expq[0].val);
                    check("eoi_write", 32'(bus.m_pwrite), 32'd1);
                    if (bus.m_penable && bus.m_pready) begin
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic do_reset();
        presetn     = 1'b0;
        bus.irq_ack = 1'b0;
        bus.m_pready = 1'b1;
        gpio_intr   = 8'h00;
        src_mask    = 8'h00;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_irq"}, 32'(bus.cpu_irq), 32'd0);
        check({tag, "_irq_id"},  32'(bus.irq_id), 32'd0);
        check({tag, "_paddr"},   32'(bus.m_paddr), 32'd0);
        check({tag, "_psel"},    32'(bus.m_psel), 32'd0);
        check({tag, "_penable"}, 32'(bus.m_penable), 32'd0);
        check({tag, "_pwrite"},  32'(bus.m_pwrite), 32'd0);
        check({tag, "_pwdata"},  bus.m_pwdata, 32'd0);
        check({tag, "_busy"},    32'(busy), 32'd0);
    endtask

    task automatic wait_irq();
        for (int i = 0; i < 40 && !bus.cpu_irq; i++) @(negedge pclk);
        check("irq_seen", 32'(bus.cpu_irq), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) @(negedge pclk);
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic serve(input logic [7:0] gpio_after);
        wait_irq();
        @(posedge pclk); #1 bus.irq_ack = 1'b1;
        @(posedge pclk); #1 bus.irq_ack = 1'b0;
        gpio_intr = gpio_after;
        @(negedge pclk);
        wait_idle();
    endtask

    initial begin
        do_reset();
        // Reset state
        presetn = 1'b0;
        #2 check_all_zero("rst");
        @(posedge pclk); #1 presetn = 1'b1;

        // Single source with exact cycle timing
        gpio_intr = 8'h10;
        push_irq(4);
        push_eoi(32'h10);
        @(negedge pclk); check("t1_irq_T", 32'(bus.cpu_irq), 32'd0);
        @(negedge pclk); check("t1_irq_T1", 32'(bus.cpu_irq), 32'd1);
        @(posedge pclk); #1 bus.irq_ack = 1'b1;
        @(posedge pclk); #1 bus.irq_ack = 1'b0; gpio_intr = 8'h00;
        @(negedge pclk);
        check("t1_psel_A1", 32'(bus.m_psel), 32'd1);
        check("t1_pen_A1", 32'(bus.m_penable), 32'd0);
        @(negedge pclk);
        check("t1_psel_A2", 32'(bus.m_psel), 32'd1);
        check("t1_pen_A2", 32'(bus.m_penable), 32'd1);
        @(negedge pclk);
        check("t1_psel_A3", 32'(bus.m_psel), 32'd0);
        check("t1_busy_A3", 32'(busy), 32'd1);
        @(negedge pclk); check("t1_busy_A4", 32'(busy), 32'd1);
        @(negedge pclk); check("t1_busy_A5", 32'(busy), 32'd0);

        // Round-robin between sources 0 and 7
        do_reset();
        gpio_intr = 8'h81;
        push_irq(0); push_eoi(32'h01);
        push_irq(7); push_eoi(32'h80);
        push_irq(0); push_eoi(32'h01);
        push_irq(7); push_eoi(32'h80);
        serve(8'h81);
        serve(8'h81);
        serve(8'h81);
        serve(8'h00);

        // Masked source 0 is never served
        do_reset();
        src_mask  = 8'h01;
        gpio_intr = 8'h03;
        push_irq(1); push_eoi(32'h02);
        serve(8'h01);
        repeat (20) @(negedge pclk);
        check("mask_no_irq", 32'(bus.cpu_irq), 32'd0);
        src_mask  = 8'h00;
        gpio_intr = 8'h00;

        // Wait states: pready low for three ACCESS cycles
        do_reset();
        gpio_intr = 8'h04;
        push_irq(2); push_eoi(32'h04);
        wait_irq();
        @(posedge pclk); #1 bus.irq_ack = 1'b1; bus.m_pready = 1'b0;
        @(posedge pclk); #1 bus.irq_ack = 1'b0; gpio_intr = 8'h00;
        repeat (3) begin @(posedge pclk); #1; end
        @(posedge pclk); #1 bus.m_pready = 1'b1;
        @(negedge pclk);
        check("ws_pen_A5", 32'(bus.m_penable), 32'd1);
        @(negedge pclk);
        check("ws_psel_A6", 32'(bus.m_psel), 32'd0);
        check("ws_busy_A6", 32'(busy), 32'd1);
        wait_idle();

        // Source drops during NOTIFY; EOI still issued
        do_reset();
        gpio_intr = 8'h20;
        push_irq(5); push_eoi(32'h20);
        wait_irq();
        @(posedge pclk); #1 gpio_intr = 8'h00;
        repeat (3) begin
            @(negedge pclk); check("drop_irq_held", 32'(bus.cpu_irq), 32'd1);
        end
        @(posedge pclk); #1 bus.irq_ack = 1'b1;
        @(posedge pclk); #1 bus.irq_ack = 1'b0;
        @(negedge pclk);
        wait_idle();

        // Stray ack in IDLE
        @(posedge pclk); #1 bus.irq_ack = 1'b1;
        @(posedge pclk); #1 bus.irq_ack = 1'b0;
        @(negedge pclk);
        check("stray_idle_busy", 32'(busy), 32'd0);
        check("stray_idle_irq", 32'(bus.cpu_irq), 32'd0);

        // Stray ack in GUARD; last_id is 5, so source 1 wins
        gpio_intr = 8'h02;
        push_irq(1); push_eoi(32'h02);
        wait_irq();
        @(posedge pclk); #1 bus.irq_ack = 1'b1;
        @(posedge pclk); #1 bus.irq_ack = 1'b0; gpio_intr = 8'h00;
        @(posedge pclk); #1;
        @(posedge pclk); #1 bus.irq_ack = 1'b1;
        @(posedge pclk); #1 bus.irq_ack = 1'b0;
        @(negedge pclk); check("stray_guard_A4", 32'(busy), 32'd1);
        @(negedge pclk); check("stray_guard_A5", 32'(busy), 32'd0);
        repeat (5) @(negedge pclk);
        check("stray_guard_irq", 32'(bus.cpu_irq), 32'd0);

        // Reset in the middle of ACCESS
        do_reset();
        gpio_intr = 8'h02;
        push_irq(1); push_eoi(32'h02);
        wait_irq();
        @(posedge pclk); #1 bus.irq_ack = 1'b1; bus.m_pready = 1'b0;
        @(posedge pclk); #1 bus.irq_ack = 1'b0;
        @(posedge pclk); #1;
        @(negedge pclk); check("mid_pen", 32'(bus.m_penable), 32'd1);
        @(posedge pclk); #1 presetn = 1'b0;
        #1 check_all_zero("async_rst");
        void'(expq.pop_front());
        gpio_intr    = 8'h81;
        bus.m_pready = 1'b1;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        push_irq(0); push_eoi(32'h01);
        serve(8'h00);

        repeat (10) @(negedge pclk);
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
